// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model answering CMD0/CMD8/CMD55/ACMD41/CMD58.
// Define SD_CRC7_CHECK_EN to verify CRC7 on CMD0 and CMD8.
module sd_spi_card_responder #(
   parameter int          NCR_BYTES         = 1,
   parameter int          ACMD41_BUSY_POLLS = 2,
   parameter logic [31:0] OCR_VALUE         = 32'hC0FF8000,
   parameter int          SYNC_STAGES       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sd_cclk,
   input  logic        sd_cmd,
   input  logic        sd_cs,
   output logic        sd_data,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        card_idle
);
   typedef enum logic [2:0] {S_IDLE, S_RX, S_DECODE, S_NCR, S_TX} state_e;

   localparam logic [5:0] NCR_LAST = 6'(8 * NCR_BYTES - 1);
   localparam logic [7:0] POLLS    = 8'(ACMD41_BUSY_POLLS);

   logic [SYNC_STAGES-1:0] cclk_sync_q, cclk_sync_d;
   logic [SYNC_STAGES-1:0] cmd_sync_q, cmd_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic        cclk_last_q, cclk_last_d;
   state_e      state_q, state_d;
   logic [47:0] frame_q, frame_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [5:0]  ncr_cnt_q, ncr_cnt_d;
   logic [39:0] tx_sr_q, tx_sr_d;
   logic [5:0]  tx_cnt_q, tx_cnt_d;
   logic        sd_data_q, sd_data_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [5:0]  cmd_index_q, cmd_index_d;
   logic [31:0] cmd_arg_q, cmd_arg_d;
   logic        card_idle_q, card_idle_d;
   logic [7:0]  poll_q, poll_d;
   logic        app_cmd_q, app_cmd_d;

   logic        cclk_s, mosi_s, cs_s, sclk_rise, sclk_fall;
   logic [5:0]  idx;
   logic [31:0] arg;
   logic [7:0]  r1;
   logic [31:0] payload;
   logic        long_resp;
   logic        crc_bad;
   logic        unused_bits;

`ifdef SD_CRC7_CHECK_EN
   logic [6:0] crc_q, crc_d;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
   endfunction

   assign unused_bits = frame_q[47];
`else
   assign unused_bits = ^{frame_q[47], frame_q[7:1]};
`endif

   assign cclk_s    = cclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = cmd_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = cclk_s & ~cclk_last_q;
   assign sclk_fall = ~cclk_s & cclk_last_q;
   assign idx       = frame_q[45:40];
   assign arg       = frame_q[39:8];

   always_comb begin
      cclk_sync_d = SYNC_STAGES'({cclk_sync_q, sd_cclk});
      cmd_sync_d  = SYNC_STAGES'({cmd_sync_q, sd_cmd});
      cs_sync_d   = SYNC_STAGES'({cs_sync_q, sd_cs});
      cclk_last_d = cclk_s;
      state_d     = state_q;
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      ncr_cnt_d   = ncr_cnt_q;
      tx_sr_d     = tx_sr_q;
      tx_cnt_d    = tx_cnt_q;
      sd_data_d   = sd_data_q;
      cmd_valid_d = 1'b0;
      cmd_index_d = cmd_index_q;
      cmd_arg_d   = cmd_arg_q;
      card_idle_d = card_idle_q;
      poll_d      = poll_q;
      app_cmd_d   = app_cmd_q;
      r1          = 8'h00;
      payload     = 32'hFFFF_FFFF;
      long_resp   = 1'b0;
      crc_bad     = 1'b0;
`ifdef SD_CRC7_CHECK_EN
      crc_d       = crc_q;
`endif
      if (cs_s) begin
         state_d   = S_IDLE;
         sd_data_d = 1'b1;
         bit_cnt_d = 6'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               sd_data_d = 1'b1;
               if (sclk_rise && !mosi_s) begin
                  state_d   = S_RX;
                  bit_cnt_d = 6'd1;
                  frame_d   = 48'd0;
`ifdef SD_CRC7_CHECK_EN
                  crc_d     = 7'd0;
`endif
               end
            end
            S_RX: begin
               if (sclk_rise) begin
                  frame_d   = {frame_q[46:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 6'd1;
`ifdef SD_CRC7_CHECK_EN
                  if (bit_cnt_q < 6'd40) crc_d = crc7_step(crc_q, mosi_s);
`endif
                  if (bit_cnt_q == 6'd47)
                     state_d = (frame_d[46] && frame_d[0]) ? S_DECODE : S_IDLE;
               end
            end
            S_DECODE: begin
               cmd_valid_d = 1'b1;
               cmd_index_d = idx;
               cmd_arg_d   = arg;
               ncr_cnt_d   = 6'd0;
               state_d     = S_NCR;
`ifdef SD_CRC7_CHECK_EN
               crc_bad = (idx == 6'd0 || idx == 6'd8) && (crc_q != frame_q[7:1]);
`endif
               if (crc_bad) begin
                  r1 = {4'b0, 1'b1, 2'b0, card_idle_q};
               end else begin
                  app_cmd_d = 1'b0;
                  r1        = {5'b0, 1'b1, 1'b0, card_idle_q};
                  unique case (1'b1)
                     idx == 6'd0: begin
                        card_idle_d = 1'b1;
                        poll_d      = 8'd0;
                        r1          = 8'h01;
                     end
                     idx == 6'd8: begin
                        r1        = {7'b0, card_idle_q};
                        payload   = {20'h0, arg[11:8], arg[7:0]};
                        long_resp = 1'b1;
                     end
                     idx == 6'd55: begin
                        r1        = {7'b0, card_idle_q};
                        app_cmd_d = 1'b1;
                     end
                     idx == 6'd41 && app_cmd_q: begin
                        if (poll_q < POLLS) begin
                           r1     = {7'b0, card_idle_q};
                           poll_d = poll_q + 8'd1;
                        end else begin
                           card_idle_d = 1'b0;
                           r1          = 8'h00;
                        end
                     end
                     idx == 6'd58: begin
                        r1        = {7'b0, card_idle_q};
                        payload   = OCR_VALUE;
                        long_resp = 1'b1;
                     end
                     default: ;
                  endcase
               end
               tx_sr_d  = {r1, payload};
               tx_cnt_d = long_resp ? 6'd40 : 6'd8;
            end
            S_NCR: begin
               sd_data_d = 1'b1;
               if (sclk_fall) begin
                  if (ncr_cnt_q == NCR_LAST) state_d = S_TX;
                  else ncr_cnt_d = ncr_cnt_q + 6'd1;
               end
            end
            S_TX: begin
               if (sclk_fall) begin
                  if (tx_cnt_q != 6'd0) begin
                     sd_data_d = tx_sr_q[39];
                     tx_sr_d   = {tx_sr_q[38:0], 1'b1};
                     tx_cnt_d  = tx_cnt_q - 6'd1;
                  end else begin
                     sd_data_d = 1'b1;
                     state_d   = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cclk_sync_q <= '0;
         cmd_sync_q  <= '1;
         cs_sync_q   <= '1;
         cclk_last_q <= 1'b0;
         state_q     <= S_IDLE;
         frame_q     <= 48'd0;
         bit_cnt_q   <= 6'd0;
         ncr_cnt_q   <= 6'd0;
         tx_sr_q     <= '1;
         tx_cnt_q    <= 6'd0;
         sd_data_q   <= 1'b1;
         cmd_valid_q <= 1'b0;
         cmd_index_q <= 6'd0;
         cmd_arg_q   <= 32'd0;
         card_idle_q <= 1'b1;
         poll_q      <= 8'd0;
         app_cmd_q   <= 1'b0;
`ifdef SD_CRC7_CHECK_EN
         crc_q       <= 7'd0;
`endif
      end else begin
         cclk_sync_q <= cclk_sync_d;
         cmd_sync_q  <= cmd_sync_d;
         cs_sync_q   <= cs_sync_d;
         cclk_last_q <= cclk_last_d;
         state_q     <= state_d;
         frame_q     <= frame_d;
         bit_cnt_q   <= bit_cnt_d;
         ncr_cnt_q   <= ncr_cnt_d;
         tx_sr_q     <= tx_sr_d;
         tx_cnt_q    <= tx_cnt_d;
         sd_data_q   <= sd_data_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_index_q <= cmd_index_d;
         cmd_arg_q   <= cmd_arg_d;
         card_idle_q <= card_idle_d;
         poll_q      <= poll_d;
         app_cmd_q   <= app_cmd_d;
`ifdef SD_CRC7_CHECK_EN
         crc_q       <= crc_d;
`endif
      end
   end

   assign sd_data   = sd_data_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_index = cmd_index_q;
   assign cmd_arg   = cmd_arg_q;
   assign card_idle = card_idle_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder acting as an SPI host.
// SCLK half period is six system clocks; MISO is sampled just before each rise.
module tb_sd_spi_card_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sd_cclk = 1'b0;
   logic        sd_cmd = 1'b1;
   logic        sd_cs = 1'b1;
   logic        sd_data;
   logic        cmd_valid;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        card_idle;

   int n_cmp = 0;
   int n_bad = 0;
   int valid_cnt = 0;

`ifdef SD_CRC7_CHECK_EN
   localparam logic [7:0] CRC_BAD_R1 = 8'h09;
`else
   localparam logic [7:0] CRC_BAD_R1 = 8'h01;
`endif

   localparam logic [47:0] F_CMD0   = 48'h40_0000_0000_95;
   localparam logic [47:0] F_CMD0X  = 48'h40_0000_0000_97;
   localparam logic [47:0] F_CMD8   = 48'h48_0000_01AA_87;
   localparam logic [47:0] F_CMD55  = 48'h77_0000_0000_FF;
   localparam logic [47:0] F_ACMD41 = 48'h69_4000_0000_FF;
   localparam logic [47:0] F_CMD58  = 48'h7A_0000_0000_FF;
   localparam logic [47:0] F_CMD17  = 48'h51_0000_0000_FF;

   always #5 clk = ~clk;

   sd_spi_card_responder dut (
      .clk       (clk),
      .rst       (rst),
      .sd_cclk   (sd_cclk),
      .sd_cmd    (sd_cmd),
      .sd_cs     (sd_cs),
      .sd_data   (sd_data),
      .cmd_valid (cmd_valid),
      .cmd_index (cmd_index),
      .cmd_arg   (cmd_arg),
      .card_idle (card_idle)
   );

   always @(posedge clk) if (cmd_valid) valid_cnt <= valid_cnt + 1;

   task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic spi_bit(input logic mosi, output logic miso);
      @(negedge clk);
      sd_cclk = 1'b0;
      sd_cmd  = mosi;
      repeat (6) @(negedge clk);
      miso    = sd_data;
      sd_cclk = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], b);
         rx[i] = b;
      end
   endtask

   task automatic send_frame(input logic [47:0] f);
      logic [7:0] b;
      for (int i = 5; i >= 0; i--) spi_byte(f[i*8 +: 8], b);
   endtask

   task automatic cmd_chk(input string tag, input logic [47:0] f,
                          input int n, input logic [39:0] exp);
      logic [7:0]  b;
      logic [7:0]  gap;
      logic [39:0] resp;
      send_frame(f);
      spi_byte(8'hFF, gap);
      resp = '0;
      for (int i = 0; i < n; i++) begin
         spi_byte(8'hFF, b);
         resp = {resp[31:0], b};
      end
      chk({tag, "_ncr"}, {32'd0, gap}, 40'hFF);
      chk(tag, resp, exp);
   endtask

   initial begin
      logic [7:0] b;
      logic       bit_v;
      int         vc;

      repeat (4) @(negedge clk);
      chk("rst_sd_data", {39'd0, sd_data}, 40'd1);
      chk("rst_cmd_valid", {39'd0, cmd_valid}, 40'd0);
      chk("rst_cmd_index", {34'd0, cmd_index}, 40'd0);
      chk("rst_cmd_arg", {8'd0, cmd_arg}, 40'd0);
      chk("rst_card_idle", {39'd0, card_idle}, 40'd1);
      rst = 1'b0;
      sd_cs = 1'b0;
      repeat (4) @(negedge clk);

      cmd_chk("cmd0_r1", F_CMD0, 1, 40'h01);
      chk("cmd0_valid_cnt", 40'(valid_cnt), 40'd1);
      chk("cmd0_index", {34'd0, cmd_index}, 40'd0);

      cmd_chk("cmd8_r7", F_CMD8, 5, 40'h01_0000_01AA);
      chk("cmd8_arg", {8'd0, cmd_arg}, 40'h1AA);
      chk("cmd8_index", {34'd0, cmd_index}, 40'd8);

      cmd_chk("cmd55_a", F_CMD55, 1, 40'h01);
      cmd_chk("acmd41_a", F_ACMD41, 1, 40'h01);
      cmd_chk("cmd55_b", F_CMD55, 1, 40'h01);
      cmd_chk("acmd41_b", F_ACMD41, 1, 40'h01);
      chk("idle_after_2polls", {39'd0, card_idle}, 40'd1);
      cmd_chk("cmd55_c", F_CMD55, 1, 40'h01);
      cmd_chk("acmd41_c", F_ACMD41, 1, 40'h00);
      chk("idle_after_ready", {39'd0, card_idle}, 40'd0);
      cmd_chk("cmd58_r3", F_CMD58, 5, 40'h00_C0FF_8000);

      // Reset in the middle of a response that is currently driving 0.
      send_frame(F_CMD58);
      spi_byte(8'hFF, b);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, bit_v);
      chk("tx_driving_low", {39'd0, sd_data}, 40'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_tx_sd_data", {39'd0, sd_data}, 40'd1);
      chk("rst_tx_card_idle", {39'd0, card_idle}, 40'd1);
      chk("rst_tx_cmd_valid", {39'd0, cmd_valid}, 40'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      cmd_chk("cmd17_illegal", F_CMD17, 1, 40'h05);
      cmd_chk("cmd0_again", F_CMD0, 1, 40'h01);
      cmd_chk("acmd41_no55", F_ACMD41, 1, 40'h05);

      vc = valid_cnt;
      for (int i = 47; i >= 28; i--) spi_bit(F_CMD0[i], bit_v);
      @(negedge clk);
      sd_cs = 1'b1;
      repeat (10) @(negedge clk);
      chk("partial_no_valid", 40'(valid_cnt), 40'(vc));
      chk("partial_miso_high", {39'd0, sd_data}, 40'd1);
      sd_cs = 1'b0;
      repeat (4) @(negedge clk);
      cmd_chk("cmd0_after_partial", F_CMD0, 1, 40'h01);
      chk("full_valid", 40'(valid_cnt), 40'(vc + 1));

      cmd_chk("cmd0_bad_crc", F_CMD0X, 1, {32'd0, CRC_BAD_R1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sd_spi_card_responder.md
Name: sd_spi_card_responder

Overview:
- Synthesizable SD card model in SPI mode: the card end of the SPI link that the SD host block drives.
- Oversamples host SCLK, MOSI and CS on the system clock, deserialises 48-bit command frames, and returns R1/R3/R7 responses after an Ncr gap.
- Used as an on-chip loopback target for bring-up of the host sequencer and as a simulation card model.
- Covers the init subset only: CMD0, CMD8, CMD55, ACMD41 and CMD58.

Parameters:
- NCR_BYTES, 1, number of 0xFF bytes between the command end bit and the first response bit; legal range 1..8.
- ACMD41_BUSY_POLLS, 2, number of ACMD41 commands answered 0x01 (idle) before the first 0x00 answer.
- OCR_VALUE, 32'hC0FF8000, OCR returned in the R3 response (power-up done, CCS=1, 2.7–3.6 V).
- SYNC_STAGES, 2, synchroniser depth applied to sd_cclk, sd_cmd and sd_cs.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- sd_cclk  in  1  host SPI clock; must not exceed clk/8.
- sd_cmd  in  1  MOSI from host.
- sd_cs  in  1  chip select, active-low.
- sd_data  out  1  MISO to host.
- cmd_valid  out  1  one-clk pulse when a complete frame has been accepted.
- cmd_index  out  6  index of the last accepted command.
- cmd_arg  out  32  argument of the last accepted command.
- card_idle  out  1  R1 in_idle bit.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All logic runs on posedge clk.
- Reset values: sd_data=1, cmd_valid=0, cmd_index=0, cmd_arg=0, card_idle=1, state=S_IDLE, ACMD41 poll counter=0, app_cmd flag=0.
- Input synchronisation: each input passes through a SYNC_STAGES flop chain. SCLK edges are detected by comparing the last two synchronised samples.
- SPI mode 0: MOSI is sampled on detected SCLK rise; sd_data updates on detected SCLK fall.
- S_IDLE:
  - sd_data=1.
  - On SCLK rise with CS low and MOSI=0 (start bit): go to S_RX, bit counter=1.
- S_RX:
  - Shift MOSI into a 48-bit register, MSB first, on each SCLK rise.
  - At bit 48: go to S_DECODE. The frame is valid only if bit46=1 (transmission bit) and bit0=1 (end bit); otherwise drop to S_IDLE with no response.
- S_DECODE (1 clk):
  - Latch cmd_index=frame[45:40] and cmd_arg=frame[39:8]; pulse cmd_valid.
  - CMD0: card_idle<=1, poll counter<=0, app_cmd<=0; R1=0x01.
  - CMD8: R7 = {R1, 20'h0, arg[11:8], arg[7:0]}, 40 bits; echoes the voltage nibble and check pattern.
  - CMD55: R1; app_cmd<=1.
  - ACMD41 (index 41 with app_cmd=1):
    - If poll counter < ACMD41_BUSY_POLLS: R1=0x01 and counter+1.
    - Otherwise: card_idle<=0 and R1=0x00.
    - In both cases app_cmd<=0.
  - CMD58: R3 = {R1, OCR_VALUE}, 40 bits.
  - Any other command, or index 41 without app_cmd: R1 = {5'b0, 1'b1 (illegal), 1'b0, card_idle}. app_cmd<=0.
  - R1 bit0 always equals card_idle after the update.
  - Then go to S_NCR.
- S_NCR:
  - Hold sd_data=1 for 8*NCR_BYTES SCLK falls, then go to S_TX.
- S_TX:
  - Drive response MSB first; one bit per SCLK fall. The first bit appears on the first fall after Ncr.
  - After the last bit, the next fall sets sd_data=1 and the state returns to S_IDLE.
- CS high in any state: immediate return to S_IDLE, sd_data=1, partial frame discarded. card_idle, poll counter and app_cmd are kept.
- A start bit received during S_NCR or S_TX is ignored; the host must clock out the response first.
- rst asserted mid-frame or mid-response: next cycle all reset values apply, regardless of SCLK.
- SCLK activity with CS high: ignored; no state change.

Optional Feature:
- SD_CRC7_CHECK_EN: when defined, CRC7 (polynomial x^7+x^3+1, init 0) is computed over frame[47:8] as bits arrive, for CMD0 and CMD8 only.
  - On mismatch with frame[7:1]: R1 = {4'b0, 1'b1 (com_crc), 2'b0, card_idle}, 8 bits; the command has no other effect.
  - cmd_valid still pulses on a CRC mismatch.
- Undefined: CRC field ignored for all commands; no CRC logic is synthesised.

Test Plan:
- CS low, frame 40 00 00 00 00 95, then 16 SCLKs with MOSI=1 -> first 8 MISO bits 0xFF, next 8 bits 0x01; cmd_valid pulses once with cmd_index=0.
- CMD8 frame 48 00 00 01 AA 87 -> after 0xFF gap, MISO 01 00 00 01 AA; cmd_arg=0x000001AA.
- CMD55+ACMD41 (77 00 00 00 00 FF, 69 40 00 00 00 FF) three times with default params -> R1 01, 01, 00; card_idle falls after the third ACMD41. Then CMD58 -> 00 C0 FF 80 00.
- CMD17 with no prior init -> R1 0x05; CMD0 then ACMD41 without CMD55 -> 0x05.
- CS raised after 20 bits of CMD0, then lowered and a full CMD0 sent -> no response to the partial frame, 0x01 to the full frame; rst pulsed during S_TX -> sd_data=1 next clk and card_idle=1.
- With SD_CRC7_CHECK_EN, CMD0 with CRC byte 0x97 -> R1 0x09; the same frame without the macro -> 0x01.
